lfsr_ram_feeder: RTL and testbench



---
 rtl/lfsr_ram_pkg.sv | 29 ++
 rtl/lfsr_ram_feeder_sync_ram.sv | 24 ++
 rtl/lfsr_ram_feeder.sv | 140 ++++++++++++++
 tb/tb_lfsr_ram_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ram_pkg.sv
// rtl/lfsr_ram_pkg.sv - shared types, constants and LFSR helpers for lfsr_ram_feeder
package lfsr_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_GAP  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam int                LFSR_W       = 3;
  localparam int                LFSR_TAP_HI  = 2;
  localparam int                LFSR_TAP_LO  = 1;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 3'b001;
  localparam logic [3:0]        WD_LIMIT     = 4'd15;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

  // The all-zero state is a lock-up state of the LFSR.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr_ram_feeder_sync_ram.sv
// rtl/lfsr_ram_feeder_sync_ram.sv - single-port RAM, synchronous write, registered read
module sync_ram
  import lfsr_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LFSR_W-1:0] i_wdata,
  output logic [LFSR_W-1:0] o_rdata
);

  logic [LFSR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/lfsr_ram_feeder.sv
// rtl/lfsr_ram_feeder.sv - fills a RAM with an LFSR sequence and replays it to a checker
// Optional watchdog on the checker handshake: LFSR_RAM_FEEDER_TIMEOUT_EN
module lfsr_ram_feeder
  import lfsr_ram_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [LFSR_W-1:0] o_data,
  output logic              o_flag,
  input  logic              i_err,
  input  logic              i_err_done,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_err_count
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  localparam logic [LFSR_W-1:0] SEED_EFF = fix_seed(LFSR_SEED);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_rdata;
  logic                w_we;
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
  logic [3:0]          r_wd;
`endif

  assign w_we = (r_state == ST_FILL);

  sync_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_lfsr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_lfsr      <= SEED_EFF;
      o_data      <= '0;
      o_flag      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err_count <= '0;
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
      r_wd        <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      o_flag <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state     <= ST_FILL;
            r_addr      <= '0;
            r_lfsr      <= SEED_EFF;
            o_err_count <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
            o_timeout   <= 1'b0;
`endif
          end
        end
        ST_FILL: begin
          r_lfsr <= lfsr_next(r_lfsr);
          if (r_addr == LAST) begin
            r_addr  <= '0;
            r_state <= ST_RD;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_RD: begin
          r_state <= ST_SEND;
        end
        // RAM output is valid here, one cycle after the read address was held in RD.
        ST_SEND: begin
          o_data  <= w_rdata;
          o_flag  <= 1'b1;
          r_state <= ST_WAIT;
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
          r_wd    <= '0;
`endif
        end
        ST_WAIT: begin
          if (i_err_done) begin
            if (i_err && (o_err_count != CNT_MAX)) begin
              o_err_count <= o_err_count + 1'b1;
            end
            if (r_addr == LAST) begin
              r_state <= ST_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= ST_GAP;
            end
          end
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
          else if (r_wd == WD_LIMIT - 4'd1) begin
            o_timeout <= 1'b1;
            r_state   <= ST_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          r_state <= ST_RD;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ram_feeder.sv
// tb/tb_lfsr_ram_feeder.sv - directed bench for lfsr_ram_feeder, default seed and zero seed side by side
module tb_lfsr_ram_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             err;
  logic             err_done;
  logic [2:0]       data_a, data_b;
  logic             flag_a, flag_b;
  logic             busy_a, busy_b;
  logic             done_a, done_b;
  logic [ADDR_W:0]  cnt_a, cnt_b;
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
  logic             to_a, to_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

  lfsr_ram_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LFSR_SEED(3'b001)) dut_a (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_data      (data_a),
    .o_flag      (flag_a),
    .i_err       (err),
    .i_err_done  (err_done),
    .o_busy      (busy_a),
    .o_done      (done_a),
    .o_err_count (cnt_a)
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
    ,
    .o_timeout   (to_a)
`endif
  );

  lfsr_ram_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LFSR_SEED(3'b000)) dut_b (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_data      (data_b),
    .o_flag      (flag_b),
    .i_err       (err),
    .i_err_done  (err_done),
    .o_busy      (busy_b),
    .o_done      (done_b),
    .o_err_count (cnt_b)
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
    ,
    .o_timeout   (to_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_data_a"}, data_a, 0);
    check_eq({tag, "_flag_a"}, flag_a, 0);
    check_eq({tag, "_busy_a"}, busy_a, 0);
    check_eq({tag, "_done_a"}, done_a, 0);
    check_eq({tag, "_cnt_a"},  cnt_a,  0);
    check_eq({tag, "_data_b"}, data_b, 0);
    check_eq({tag, "_cnt_b"},  cnt_b,  0);
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
    check_eq({tag, "_to_a"},   to_a,   0);
`endif
  endtask

  task automatic wait_flag(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (flag_a) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // mode 0: plain run, 1: i_start pulsed during WAIT, 2: reset at entry 6, 3: no reply for entry 3
  task automatic do_run(input int mode, input string tag);
    int         seen;
    int         extra;
    int         n;
    bit         ok;
    logic [2:0] d;
    seen  = 0;
    extra = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_flag(ok);
      if (!ok) begin
        check_eq({tag, "_flag_wait_expired"}, 0, 1);
        return;
      end
      seen++;
      check_eq($sformatf("%s_data_a[%0d]", tag, i), data_a, exp_seq[i % 7]);
      check_eq($sformatf("%s_data_b[%0d]", tag, i), data_b, exp_seq[i % 7]);
      check_eq($sformatf("%s_flag_b[%0d]", tag, i), flag_b, 1);
      if (i == 0) check_eq({tag, "_busy_run"}, busy_a, 1);
      if (mode == 1 && i == 5) start = 1'b1;
      if (mode == 2 && i == 6) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset({tag, "_midreset"});
        return;
      end
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
      if (mode == 3 && i == 3) begin
        repeat (14) @(negedge clk);
        check_eq({tag, "_done_before_limit"}, done_a, 0);
        check_eq({tag, "_to_before_limit"}, to_a, 0);
        @(negedge clk);
        check_eq({tag, "_to_a"}, to_a, 1);
        check_eq({tag, "_to_b"}, to_b, 1);
        check_eq({tag, "_done_a"}, done_a, 1);
        check_eq({tag, "_busy_a"}, busy_a, 0);
        check_eq({tag, "_cnt_a"}, cnt_a, 0);
        return;
      end
`endif
      n = (i % 2 == 0) ? 2 : 6;
      for (int j = 0; j < n - 1; j++) begin
        @(negedge clk);
        start = 1'b0;
        if (flag_a) extra++;
      end
      d        = data_a;
      check_eq($sformatf("%s_hold[%0d]", tag, i), d, exp_seq[i % 7]);
      err_done = 1'b1;
      err      = (d == 3'b111);
      @(negedge clk);
      err_done = 1'b0;
      err      = 1'b0;
      if (flag_a) extra++;
      // Stray reply during GAP must not be counted.
      if (i == 2) begin
        err_done = 1'b1;
        err      = 1'b1;
        @(negedge clk);
        err_done = 1'b0;
        err      = 1'b0;
      end
    end
    check_eq({tag, "_done_a"}, done_a, 1);
    check_eq({tag, "_busy_a"}, busy_a, 0);
    check_eq({tag, "_cnt_a"},  cnt_a,  2);
    check_eq({tag, "_done_b"}, done_b, 1);
    check_eq({tag, "_cnt_b"},  cnt_b,  2);
    check_eq({tag, "_flags"},  seen,   DEPTH);
    check_eq({tag, "_extra_flags"}, extra, 0);
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    err      = 1'b0;
    err_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;
    @(negedge clk);
    do_run(0, "run_basic");
    do_run(1, "run_start_in_wait");
    do_run(2, "run_reset");
    do_run(0, "run_after_reset");
`ifdef LFSR_RAM_FEEDER_TIMEOUT_EN
    do_run(3, "run_timeout");
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
